// File: rtl/enc_pkg.sv
// Shared constants for the request encoder: FSM state encoding and arbitration modes.
package enc_pkg;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_HOLD = 1'b1;

  localparam int RR_FIXED = 0;
  localparam int RR_ROUND = 1;

  typedef enum logic {
    S_IDLE = ST_IDLE,
    S_HOLD = ST_HOLD
  } enc_state_e;

endpackage

// File: rtl/prio_find.sv
// Combinational index search over a request mask.
// rr=0: highest set index. rr=1: first set index at or above start, wrapping N-1 -> 0.
module prio_find #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic [N-1:0] mask,
  input  logic [W-1:0] start,
  input  logic         rr,
  output logic [W-1:0] idx,
  output logic         any
);

  // Scan so that the preferred candidate is written last and therefore wins.
  always_comb begin
    idx = '0;
    if (rr) begin
      // Descending offsets: the smallest offset from start overrides the rest.
      // The W-bit add wraps naturally because N is a power of two.
      for (int k = N - 1; k >= 0; k--) begin
        if (mask[start + W'(k)]) idx = start + W'(k);
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (mask[i]) idx = W'(i);
      end
    end
  end

  assign any = |mask;

endmodule

// File: rtl/req_encoder.sv
// Sequential N-to-log2(N) request encoder.
// Sticky pending mask, one binary index presented at a time on a valid/ready handshake;
// the served bit clears on acceptance unless it is re-requested in the same cycle.
//
//  state  | meaning
//  IDLE   | no code presented; selects a pending index when one exists
//  HOLD   | code/code_valid stable until the consumer accepts
module req_encoder
  import enc_pkg::*;
#(
  parameter int N  = 8,
  parameter int W  = 3,
  parameter int RR = RR_FIXED
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         e,
  input  logic [N-1:0] req,
  output logic         code_valid,
  input  logic         code_ready,
  output logic [W-1:0] code,
  output logic [N-1:0] pending
);

  if (N < 2 || W != $clog2(N) || (1 << W) != N) begin : g_bad_width
    $error("req_encoder: W must equal log2(N) and N must be a power of two >= 2");
  end

  enc_state_e   state_q, state_d;
  logic [N-1:0] pending_q, pending_d;
  logic [W-1:0] code_q, code_d;
  logic         valid_q, valid_d;
  logic [W-1:0] last_q, last_d;

  logic         hs;
  logic [N-1:0] clr_mask;
  logic [W-1:0] sel_idx;
  logic         sel_any;
  logic         rr_mode;

  assign rr_mode = (RR != RR_FIXED);
  assign hs      = valid_q & code_ready;

  // Search starts one past the last served index; reset value N-1 makes it start at 0.
  prio_find #(
    .N(N),
    .W(W)
  ) u_prio_find (
    .mask (pending_q),
    .start(last_q + W'(1)),
    .rr   (rr_mode),
    .idx  (sel_idx),
    .any  (sel_any)
  );

  // One-hot of the presented code, only on an accepted handshake.
  always_comb begin
    clr_mask = '0;
    for (int i = 0; i < N; i++) begin
      clr_mask[i] = hs && (code_q == W'(i));
    end
  end

  // Clear first, then OR in new requests so a same-cycle re-request keeps the bit set.
  always_comb begin
    pending_d = (pending_q & ~clr_mask) | (e ? req : '0);
  end

  // Next-state and output register logic for the IDLE/HOLD handshake FSM.
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    valid_d = valid_q;
    last_d  = last_q;
    unique case (state_q)
      S_IDLE: begin
        if (sel_any) begin
          code_d  = sel_idx;
          valid_d = 1'b1;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (code_ready) begin
          last_d  = code_q;
          valid_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State, pending mask, code/valid and round-robin pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pending_q <= '0;
      code_q    <= '0;
      valid_q   <= 1'b0;
      last_q    <= W'(N - 1);
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      code_q    <= code_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
    end
  end

  assign code_valid = valid_q;
  assign code       = code_q;
  assign pending    = pending_q;

endmodule

// File: tb/tb_req_encoder.sv
// Self-checking bench for req_encoder: two instances (fixed priority and round-robin),
// directed sequences, a vector table and randomized traffic against a behavioural model.
module tb_req_encoder;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [1:0]      e_s;
  logic [1:0][7:0] req_s;
  logic [1:0]      rdy_s;
  logic [1:0]      vld_s;
  logic [1:0][2:0] code_s;
  logic [1:0][7:0] pend_s;

  int n_chk  = 0;
  int n_fail = 0;

  // Behavioural model state, one per instance (index = RR mode).
  logic [7:0] m_pend[2];
  bit         m_vld[2];
  int         m_code[2];
  int         m_last[2];

  int got[$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    req_encoder #(.N(8), .W(3), .RR(g)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .e         (e_s[g]),
      .req       (req_s[g]),
      .code_valid(vld_s[g]),
      .code_ready(rdy_s[g]),
      .code      (code_s[g]),
      .pending   (pend_s[g])
    );
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Index the consumer should receive, from the arbitration rules.
  function automatic int pick(int m, logic [7:0] p, int last);
    if (m == 0) begin
      for (int i = 7; i >= 0; i--) if (p[i]) return i;
    end else begin
      for (int k = 1; k <= 8; k++) if (p[(last + k) % 8]) return (last + k) % 8;
    end
    return 0;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_pend[m] = 8'h00;
      m_vld[m]  = 1'b0;
      m_code[m] = 0;
      m_last[m] = 7;
    end
  endtask

  // Advance one clock; model uses the inputs present before the edge.
  task automatic tick();
    logic [7:0] np[2];
    bit         nv[2];
    int         nc[2];
    int         nl[2];
    for (int m = 0; m < 2; m++) begin
      np[m] = m_pend[m];
      nv[m] = m_vld[m];
      nc[m] = m_code[m];
      nl[m] = m_last[m];
      if (m_vld[m] && rdy_s[m]) begin
        np[m][m_code[m]] = 1'b0;
        nl[m] = m_code[m];
        nv[m] = 1'b0;
      end else if (!m_vld[m] && m_pend[m] != 0) begin
        nc[m] = pick(m, m_pend[m], m_last[m]);
        nv[m] = 1'b1;
      end
      if (e_s[m]) np[m] = np[m] | req_s[m];
    end
    @(posedge clk);
    #1;
    for (int m = 0; m < 2; m++) begin
      m_pend[m] = np[m];
      m_vld[m]  = nv[m];
      m_code[m] = nc[m];
      m_last[m] = nl[m];
    end
    if (!rst_n) model_reset();
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("model_pending[%0d]", m), 32'(pend_s[m]), 32'(m_pend[m]));
      chk($sformatf("model_valid[%0d]", m), 32'(vld_s[m]), 32'(m_vld[m]));
      chk($sformatf("model_code[%0d]", m), 32'(code_s[m]), 32'(m_code[m]));
    end
  endtask

  // With ready held high, gather n presented codes and check the 2-cycle spacing.
  task automatic collect(int m, int n);
    int t    = 0;
    int prev = -1;
    got.delete();
    while (got.size() < n && t < 64) begin
      tick();
      t++;
      if (vld_s[m]) begin
        if (prev >= 0) chk("code_spacing", 32'(t - prev), 32'd2);
        prev = t;
        got.push_back(int'(code_s[m]));
      end
    end
    if (got.size() < n) chk("collect_timeout", 32'(got.size()), 32'(n));
  endtask

  task automatic drain(int m);
    int t = 0;
    req_s[m] = 8'h00;
    rdy_s[m] = 1'b1;
    while ((pend_s[m] != 0 || vld_s[m]) && t < 40) begin
      tick();
      t++;
    end
    chk("drain_done", 32'(pend_s[m] == 0 && !vld_s[m]), 32'd1);
  endtask

  typedef struct {
    logic [7:0] req;
    logic [2:0] exp_code;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{8'h01, 3'd0};
    vecs[1] = '{8'h80, 3'd7};
    vecs[2] = '{8'h20, 3'd5};
    vecs[3] = '{8'h5A, 3'd6};
    vecs[4] = '{8'hFF, 3'd7};
    vecs[5] = '{8'h13, 3'd4};

    // T1: reset held with requests active.
    rst_n = 1'b0;
    e_s   = 2'b11;
    req_s = '{8'hFF, 8'hFF};
    rdy_s = 2'b00;
    model_reset();
    #3;
    for (int c = 0; c < 3; c++) begin
      tick();
      for (int m = 0; m < 2; m++) begin
        chk("reset_pending", 32'(pend_s[m]), 32'h0);
        chk("reset_valid", 32'(vld_s[m]), 32'h0);
        chk("reset_code", 32'(code_s[m]), 32'h0);
      end
    end
    req_s = '{8'h00, 8'h00};
    rst_n = 1'b1;
    tick();

    // T2: single request, fixed priority.
    rdy_s[0] = 1'b1;
    req_s[0] = 8'h20;
    tick();
    chk("t2_pending_set", 32'(pend_s[0]), 32'h20);
    chk("t2_valid_early", 32'(vld_s[0]), 32'h0);
    req_s[0] = 8'h00;
    tick();
    chk("t2_valid", 32'(vld_s[0]), 32'h1);
    chk("t2_code", 32'(code_s[0]), 32'h5);
    tick();
    chk("t2_pending_clr", 32'(pend_s[0]), 32'h0);
    chk("t2_valid_drop", 32'(vld_s[0]), 32'h0);

    // T3: fixed order 7,5,2.
    req_s[0] = 8'hA4;
    tick();
    req_s[0] = 8'h00;
    collect(0, 3);
    if (got.size() == 3) begin
      chk("t3_code0", 32'(got[0]), 32'd7);
      chk("t3_code1", 32'(got[1]), 32'd5);
      chk("t3_code2", 32'(got[2]), 32'd2);
    end
    drain(0);

    // Vector table: first code presented for a multi-hot burst, fixed priority.
    rdy_s[0] = 1'b0;
    for (int v = 0; v < 6; v++) begin
      req_s[0] = vecs[v].req;
      tick();
      req_s[0] = 8'h00;
      tick();
      chk($sformatf("vec%0d_valid", v), 32'(vld_s[0]), 32'h1);
      chk($sformatf("vec%0d_code", v), 32'(code_s[0]), 32'(vecs[v].exp_code));
      drain(0);
      rdy_s[0] = 1'b0;
    end

    // T4: round-robin order 2,5,7 then 2,7 from last=7, then all eight once each.
    rdy_s[1] = 1'b1;
    req_s[1] = 8'hA4;
    tick();
    req_s[1] = 8'h00;
    collect(1, 3);
    if (got.size() == 3) begin
      chk("t4_code0", 32'(got[0]), 32'd2);
      chk("t4_code1", 32'(got[1]), 32'd5);
      chk("t4_code2", 32'(got[2]), 32'd7);
    end
    drain(1);
    req_s[1] = 8'h84;
    tick();
    req_s[1] = 8'h00;
    collect(1, 2);
    if (got.size() == 2) begin
      chk("t4_wrap0", 32'(got[0]), 32'd2);
      chk("t4_wrap1", 32'(got[1]), 32'd7);
    end
    drain(1);
    req_s[1] = 8'hFF;
    tick();
    req_s[1] = 8'h00;
    collect(1, 8);
    for (int i = 0; i < got.size(); i++) chk($sformatf("t4_all%0d", i), 32'(got[i]), 32'(i));
    drain(1);

    // T5: backpressure holds code 3 while bit 0 keeps arriving.
    rdy_s[0] = 1'b0;
    req_s[0] = 8'h08;
    tick();
    req_s[0] = 8'h01;
    tick();
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("t5_hold_valid", 32'(vld_s[0]), 32'h1);
      chk("t5_hold_code", 32'(code_s[0]), 32'h3);
    end
    chk("t5_pending", 32'(pend_s[0]), 32'h09);
    req_s[0] = 8'h00;
    rdy_s[0] = 1'b1;
    tick();
    chk("t5_after_hs", 32'(pend_s[0]), 32'h01);
    tick();
    chk("t5_next_code", 32'(code_s[0]), 32'h0);
    chk("t5_next_valid", 32'(vld_s[0]), 32'h1);
    drain(0);

    // T6: set wins over clear, e=0 blocks capture, async reset mid-HOLD.
    rdy_s[0] = 1'b0;
    req_s[0] = 8'h08;
    tick();
    req_s[0] = 8'h00;
    tick();
    chk("t6_code", 32'(code_s[0]), 32'h3);
    rdy_s[0] = 1'b1;
    req_s[0] = 8'h08;
    tick();
    chk("t6_set_wins", 32'(pend_s[0]), 32'h08);
    req_s[0] = 8'h00;
    rdy_s[0] = 1'b0;
    tick();
    chk("t6_reissue", 32'(vld_s[0]), 32'h1);
    e_s[0]   = 1'b0;
    req_s[0] = 8'hFF;
    for (int c = 0; c < 3; c++) tick();
    chk("t6_enable_off", 32'(pend_s[0]), 32'h08);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(vld_s[0]), 32'h0);
    chk("t6_rst_code", 32'(code_s[0]), 32'h0);
    chk("t6_rst_pending", 32'(pend_s[0]), 32'h0);
    model_reset();
    tick();
    e_s   = 2'b11;
    req_s = '{8'h00, 8'h00};
    rdy_s = 2'b00;
    rst_n = 1'b1;
    tick();

    // Randomized traffic on both instances against the model.
    for (int c = 0; c < 2000; c++) begin
      for (int m = 0; m < 2; m++) begin
        req_s[m] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
        e_s[m]   = ($urandom_range(0, 4) != 0);
        rdy_s[m] = ($urandom_range(0, 2) != 0);
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
